// File: rtl/whack_round_ctrl.sv
// whack_round_ctrl - round sequencer for the LED whack game.
//
// Starts a fixed-length round on a go press and strobes `change` so the
// datapath loads a new random LED. The strobe interval shortens as the score
// climbs through difficulty levels. At end of round it latches the session
// high score.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-low reset
//   go_btn      debounced start button (level, active high)
//   score[6:0]  current score from the LED/score datapath
//   start       high while a round is in progress
//   change      one-cycle strobe: datapath loads a new LED
//   time_left   remaining ticks in the round
//   level       difficulty level, saturates at 15
//   game_over   high in DONE
//   high_score  best score since reset
//   new_high    one-cycle pulse when high_score is updated
//
// Optional build macro WHACK_PAUSE_EN adds:
//   pause_btn   debounced pause button; a rising edge in PLAY toggles pause
//   paused      high while the round clock is frozen
//
// state | meaning
// IDLE  | after reset, waiting for the first go press
// PLAY  | round running: ticks, change strobes, level tracking
// DONE  | round over, high score sampled, waiting for go press

module whack_round_ctrl #(
  parameter int TICK_DIV    = 500000,
  parameter int ROUND_TICKS = 3000,
  parameter int CHG_INIT    = 100,
  parameter int CHG_STEP    = 10,
  parameter int CHG_MIN     = 30,
  parameter int LEVEL_PTS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_btn,
  input  logic [6:0]  score,
`ifdef WHACK_PAUSE_EN
  input  logic        pause_btn,
  output logic        paused,
`endif
  output logic        start,
  output logic        change,
  output logic [11:0] time_left,
  output logic [3:0]  level,
  output logic        game_over,
  output logic [6:0]  high_score,
  output logic        new_high
);

  localparam int TICK_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t            state, state_nxt;
  logic              go_q, go_armed, go_press, enter_play;
  logic [TICK_W-1:0] tick_cnt;
  logic [11:0]       chg_cnt, interval;
  logic [7:0]        next_thresh;
  logic [1:0]        first_dly;
  logic              done_first;
  logic              frozen, run, tick, round_end, chg_due;
  int                iv_raw;

  // go_armed stays low until go_btn has been seen low after reset, so a
  // button held through reset cannot start a round on its own.
  assign go_press   = go_btn && !go_q && go_armed;
  assign enter_play = go_press && (state != PLAY);
  assign run        = (state == PLAY) && !frozen;
  assign tick       = run && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign round_end  = tick && (time_left == 12'd1);
  assign chg_due    = tick && (chg_cnt == 12'd1);

  always_comb begin
    iv_raw   = CHG_INIT - int'(level) * CHG_STEP;
    interval = 12'(CHG_MIN);
    if (iv_raw > CHG_MIN) interval = 12'(iv_raw);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go_press)  state_nxt = PLAY;
      PLAY:    if (round_end) state_nxt = DONE;
      DONE:    if (go_press)  state_nxt = PLAY;
      default:                state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    start     = (state == PLAY);
    game_over = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      go_q        <= 1'b0;
      go_armed    <= 1'b0;
      tick_cnt    <= '0;
      chg_cnt     <= '0;
      time_left   <= '0;
      level       <= '0;
      next_thresh <= '0;
      first_dly   <= '0;
      done_first  <= 1'b0;
      change      <= 1'b0;
      new_high    <= 1'b0;
      high_score  <= '0;
    end else begin
      go_q     <= go_btn;
      go_armed <= go_armed || !go_btn;
      change   <= 1'b0;
      new_high <= 1'b0;

      // Score is sampled one cycle after start falls so a final hit counts.
      if (state == DONE && done_first) begin
        done_first <= 1'b0;
        if (score > high_score) begin
          high_score <= score;
          new_high   <= 1'b1;
        end
      end

      if (enter_play) begin
        time_left   <= 12'(ROUND_TICKS);
        level       <= '0;
        next_thresh <= 8'(LEVEL_PTS);
        tick_cnt    <= '0;
        chg_cnt     <= 12'(CHG_INIT);
        first_dly   <= 2'b01;
        done_first  <= 1'b0;
      end else if (state == PLAY) begin
        if ({1'b0, score} >= next_thresh && level != 4'd15) begin
          level       <= level + 4'd1;
          next_thresh <= next_thresh + 8'(LEVEL_PTS);
        end
        if (run) begin
          // Delayed first strobe lands 2 cycles after start rises.
          first_dly <= {first_dly[0], 1'b0};
          change    <= (first_dly[1] || chg_due) && !round_end;
          if (tick) begin
            tick_cnt  <= '0;
            time_left <= time_left - 12'd1;
            if (round_end)    done_first <= 1'b1;
            if (chg_due)      chg_cnt    <= interval;
            else              chg_cnt    <= chg_cnt - 12'd1;
          end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
          end
        end
      end
    end
  end

`ifdef WHACK_PAUSE_EN
  logic pause_q, paused_r;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_q  <= 1'b0;
      paused_r <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      if (state_nxt != PLAY)
        paused_r <= 1'b0;
      else if (state == PLAY && pause_btn && !pause_q)
        paused_r <= !paused_r;
    end
  end

  assign paused = paused_r;
  assign frozen = paused_r;
`else
  assign frozen = 1'b0;
`endif

endmodule

// File: tb/tb_whack_round_ctrl.sv
// Self-checking bench for whack_round_ctrl with small timing parameters.
module tb_whack_round_ctrl;

  localparam int TD = 4, RT = 20, CI = 5, CS = 1, CM = 2, LP = 4;

  logic        clk = 1'b0;
  logic        rst, go_btn;
  logic [6:0]  score;
  logic        start, change, game_over, new_high;
  logic [11:0] time_left;
  logic [3:0]  level;
  logic [6:0]  high_score;
`ifdef WHACK_PAUSE_EN
  logic        pause_btn, paused;
`endif

  whack_round_ctrl #(
    .TICK_DIV(TD), .ROUND_TICKS(RT), .CHG_INIT(CI),
    .CHG_STEP(CS), .CHG_MIN(CM), .LEVEL_PTS(LP)
  ) dut (
    .clk(clk), .rst(rst), .go_btn(go_btn), .score(score),
`ifdef WHACK_PAUSE_EN
    .pause_btn(pause_btn), .paused(paused),
`endif
    .start(start), .change(change), .time_left(time_left), .level(level),
    .game_over(game_over), .high_score(high_score), .new_high(new_high)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int exp_chg_q[$];
  bit sb_on = 1'b0;
  int chg_seen = 0, nh_seen = 0;

  typedef struct {
    int score; int lvl; int high; int nh; int chg;
  } row_t;
  row_t rows[5];
  row_t exp_q[$];

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Change-strobe scoreboard: expected cycles are queued when a round starts.
  always @(negedge clk) begin
    int e;
    if (change) begin
      chg_seen++;
      if (sb_on) begin
        n_cmp++;
        if (exp_chg_q.size() == 0) begin
          n_bad++;
          $display("FAIL change_sb: unexpected change at cycle %0d", cyc);
        end else begin
          e = exp_chg_q.pop_front();
          if (e != cyc) begin
            n_bad++;
            $display("FAIL change_sb: change at cycle %0d expected %0d", cyc, e);
          end
        end
      end
    end
    if (new_high) nh_seen++;
  end

  task automatic press_go(output int t0);
    int i;
    @(negedge clk) go_btn = 1'b1;
    @(negedge clk) go_btn = 1'b0;
    i = 0;
    while (!start && i < 10) begin @(negedge clk); i++; end
    chk("start_rise", int'(start), 1);
    t0 = cyc;
  endtask

  task automatic wait_done(input int limit);
    int i;
    i = 0;
    while (start && i < limit) begin @(negedge clk); i++; end
    chk("round_end_seen", int'(start), 0);
  endtask

  task automatic push_chg(input int t0, input int a, input int b, input int c, input int d);
    exp_chg_q.delete();
    exp_chg_q.push_back(t0 + a);
    exp_chg_q.push_back(t0 + b);
    exp_chg_q.push_back(t0 + c);
    exp_chg_q.push_back(t0 + d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tl, started;
    row_t er;

    rows[0] = '{score: 9,  lvl: 2, high: 9,  nh: 1, chg: 6};
    rows[1] = '{score: 9,  lvl: 2, high: 9,  nh: 0, chg: 6};
    rows[2] = '{score: 11, lvl: 2, high: 11, nh: 1, chg: 6};
    rows[3] = '{score: 5,  lvl: 1, high: 11, nh: 0, chg: 5};
    rows[4] = '{score: 20, lvl: 5, high: 20, nh: 1, chg: 9};

    rst = 1'b0; go_btn = 1'b0; score = '0;
`ifdef WHACK_PAUSE_EN
    pause_btn = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_start", int'(start), 0);
    chk("rst_change", int'(change), 0);
    chk("rst_time_left", int'(time_left), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_high", int'(high_score), 0);
    chk("rst_new_high", int'(new_high), 0);
    rst = 1'b1;
    @(negedge clk);

    // Round 1: score 0, level 0; the change due on the final tick is dropped.
    press_go(t0);
    push_chg(t0, 2, 20, 40, 60);
    sb_on = 1'b1; nh_seen = 0;
    chk("r1_time_left_init", int'(time_left), RT);
    chk("r1_game_over_play", int'(game_over), 0);
    wait_done(200);
    chk("r1_len", cyc - t0, 80);
    chk("r1_final_change", int'(change), 0);
    chk("r1_time_left_end", int'(time_left), 0);
    chk("r1_game_over", int'(game_over), 1);
    repeat (2) @(negedge clk);
    chk("r1_high", int'(high_score), 0);
    chk("r1_new_high", nh_seen, 0);
    chk("r1_chg_missing", exp_chg_q.size(), 0);
    sb_on = 1'b0;

    // High-score and level table: score held from the start of each round.
    for (int r = 0; r < 5; r++) begin
      press_go(t0);
      score = 7'(rows[r].score);
      exp_q.push_back(rows[r]);
      chg_seen = 0; nh_seen = 0;
      wait_done(200);
      tl = cyc - t0;
      repeat (2) @(negedge clk);
      er = exp_q.pop_front();
      chk($sformatf("row%0d_len", r), tl, 80);
      chk($sformatf("row%0d_level", r), int'(level), er.lvl);
      chk($sformatf("row%0d_high", r), int'(high_score), er.high);
      chk($sformatf("row%0d_new_high", r), nh_seen, er.nh);
      chk($sformatf("row%0d_changes", r), chg_seen, er.chg);
    end

    // Score ramp: intervals 5,4,3 then clamped at 2 ticks.
    press_go(t0);
    exp_chg_q.delete();
    foreach (rows[k]) if (k < 0) exp_chg_q.push_back(0);
    exp_chg_q.push_back(t0 + 2);  exp_chg_q.push_back(t0 + 20);
    exp_chg_q.push_back(t0 + 36); exp_chg_q.push_back(t0 + 48);
    exp_chg_q.push_back(t0 + 56); exp_chg_q.push_back(t0 + 64);
    exp_chg_q.push_back(t0 + 72);
    sb_on = 1'b1; nh_seen = 0;
    score = 7'd4;
    while (cyc < t0 + 5) @(negedge clk);
    chk("ramp_level1", int'(level), 1);
    while (cyc < t0 + 25) @(negedge clk);
    score = 7'd8;
    @(negedge clk); @(negedge clk);
    chk("ramp_level2", int'(level), 2);
    while (cyc < t0 + 40) @(negedge clk);
    score = 7'd12;
    @(negedge clk); @(negedge clk);
    chk("ramp_level3", int'(level), 3);
    wait_done(200);
    chk("ramp_len", cyc - t0, 80);
    repeat (2) @(negedge clk);
    chk("ramp_high", int'(high_score), 20);
    chk("ramp_new_high", nh_seen, 0);
    chk("ramp_chg_missing", exp_chg_q.size(), 0);
    sb_on = 1'b0;

    // Reset mid-round with go held high through reset.
    press_go(t0);
    score = 7'd12;
    tl = 0;
    while (time_left != 12'd10 && tl < 200) begin @(negedge clk); tl++; end
    chk("mid_tl10", int'(time_left), 10);
    rst = 1'b0; go_btn = 1'b1;
    @(negedge clk);
    chk("mid_rst_start", int'(start), 0);
    chk("mid_rst_time_left", int'(time_left), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_high", int'(high_score), 0);
    chk("mid_rst_game_over", int'(game_over), 0);
    rst = 1'b1;
    started = 0;
    repeat (6) begin @(negedge clk); if (start) started = 1; end
    chk("go_held_no_start", started, 0);
    go_btn = 1'b0;
    @(negedge clk);

    press_go(t0);
    score = 7'd0;
`ifdef WHACK_PAUSE_EN
    // Pause lands on the tick that takes time_left to 12, for 50 cycles.
    push_chg(t0, 2, 20, 90, 110);
    sb_on = 1'b1;
    while (cyc < t0 + 31) @(negedge clk);
    pause_btn = 1'b1;
    @(negedge clk);
    chk("pause_on", int'(paused), 1);
    chk("pause_tl", int'(time_left), 12);
    pause_btn = 1'b0;
    started = 0;
    while (cyc < t0 + 81) begin
      @(negedge clk);
      if (time_left != 12'd12 || !start) started++;
    end
    chk("pause_frozen_bad", started, 0);
    pause_btn = 1'b1;
    @(negedge clk);
    chk("pause_off", int'(paused), 0);
    pause_btn = 1'b0;
    wait_done(200);
    chk("pause_len", cyc - t0, 130);
    chk("pause_cleared", int'(paused), 0);
`else
    push_chg(t0, 2, 20, 40, 60);
    sb_on = 1'b1;
    wait_done(200);
    chk("post_rst_len", cyc - t0, 80);
`endif
    repeat (2) @(negedge clk);
    chk("final_chg_missing", exp_chg_q.size(), 0);
    sb_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/whack_round_ctrl.md
Name: whack_round_ctrl

Overview:
- Round sequencer for the LED whack game datapath (3 LEDs, 3 buttons, 7-bit score).
- Generates the game's `start` level and `change` strobes.
- Times a fixed-length round and raises difficulty as score grows by shortening the LED change interval.
- Latches the session high score at end of round.

Parameters:
- TICK_DIV, 500000: clk cycles per game tick (10 ms at 50 MHz); min 2.
- ROUND_TICKS, 3000: ticks per round (30 s); max 4095.
- CHG_INIT, 100: ticks between change strobes at level 0.
- CHG_STEP, 10: interval reduction per level.
- CHG_MIN, 30: floor on change interval; CHG_MIN >= 1.
- LEVEL_PTS, 8: score points per level-up.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low
- go_btn  input  1  debounced start button, active high, level
- score  input  7  current score from LED/score datapath
- start  output  1  high while a round is in progress
- change  output  1  one-cycle strobe: datapath loads new random LED
- time_left  output  12  remaining ticks in round
- level  output  4  current difficulty level, saturates at 15
- game_over  output  1  high in DONE
- high_score  output  7  best score since reset
- new_high  output  1  one-cycle pulse when high_score updated

Behaviour:
- Clock and reset: all logic on posedge clk. rst==0 at an edge forces:
  - state=IDLE; start=0, change=0, game_over=0, new_high=0.
  - time_left=0, level=0, high_score=0; tick/interval counters=0; go edge register=0.
- Reset mid-round aborts immediately, with no high-score update.
- go_press = go_btn high this cycle and low the previous cycle (registered edge detect).
- IDLE: on go_press -> PLAY.
- PLAY entry (same edge):
  - start=1, time_left=ROUND_TICKS, level=0, next_thresh=LEVEL_PTS.
  - tick_cnt=0, chg_cnt=CHG_INIT, game_over=0.
- First change strobe is exactly 2 cycles after start rises, so the datapath has left its wait state.
- PLAY tick generation:
  - tick_cnt counts 0..TICK_DIV-1; `tick` is asserted when tick_cnt==TICK_DIV-1.
  - On tick: time_left -= 1 and chg_cnt -= 1.
  - If chg_cnt==1 on a tick: change=1 for that cycle and chg_cnt reloads with interval = max(CHG_MIN, CHG_INIT - level*CHG_STEP).
  - Compute the interval in signed arithmetic of at least 12 bits; a negative result clamps to CHG_MIN.
- Level tracking:
  - Every cycle in PLAY: if score >= next_thresh and level<15, then level+=1 and next_thresh+=LEVEL_PTS.
  - At most one level per cycle.
  - next_thresh is 8 bits, so there is no wrap at 127.
- End of round: on the tick where time_left goes 1->0:
  - -> DONE; start=0.
  - Any change due on the same tick is suppressed; end of round wins.
- go_press during PLAY is ignored.
- DONE:
  - game_over=1.
  - On the first DONE cycle, sample score (1 cycle after start falls, to catch a final hit).
  - If score > high_score: high_score=score and new_high pulses 1 cycle. Equal score gives no update.
  - go_press -> PLAY with full re-init as above; high_score is kept. The datapath clears score on the start rise.
- Outputs are registered; time_left holds 0 and level holds its value through DONE.

Optional Feature:
- Macro: WHACK_PAUSE_EN.
- When defined: adds input `pause_btn` (1-bit, debounced) and output `paused` (1-bit, reset 0).
  - A pause_btn rising edge in PLAY toggles `paused`.
  - While paused, tick_cnt, time_left and chg_cnt freeze; change=0; start stays 1; level tracking continues.
  - `paused` clears on entering DONE or IDLE.
- When undefined: no extra ports; behaviour as above.

Test Plan:
Bench parameters: TICK_DIV=4, ROUND_TICKS=20, CHG_INIT=5, CHG_STEP=1, CHG_MIN=2, LEVEL_PTS=4.
- Reset then go pulse, score held 0 -> start rises; change strobe 2 cycles later; subsequent changes every 20 cycles; start falls 80 cycles after rising; game_over=1; high_score stays 0; new_high never pulses.
- Ramp score 0->12 early in round -> level steps 1,2,3; change spacing shrinks to 4,3,2 ticks and clamps at 2 ticks (8 cycles) for levels >= 3.
- Round ends with score 9, second round ends with score 9, third with 11 -> high_score 9, 9, 11; new_high pulses after rounds 1 and 3 only.
- Configure so a change is due on the final tick -> no change strobe that cycle; DONE entered; time_left=0.
- rst low mid-PLAY (time_left=10) -> next edge: start=0, time_left=0, level=0, high_score=0, state IDLE; go_btn held high through reset does not start a round until released and pressed again.
- With WHACK_PAUSE_EN: pause at time_left=12 for 50 cycles -> time_left stays 12 and no change strobes; after unpause, round completes 48 cycles later.
